// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan-bus decoder: the legal segment
// patterns (seg[0]=a .. seg[6]=g, active-low), the FSM state encoding and the frame mask.
package seg_scan_decoder_pkg;

    localparam logic [0:6] SEG_0 = 7'b0000001;
    localparam logic [0:6] SEG_1 = 7'b1001111;
    localparam logic [0:6] SEG_2 = 7'b0010010;
    localparam logic [0:6] SEG_3 = 7'b0000110;
    localparam logic [0:6] SEG_4 = 7'b1001100;
    localparam logic [0:6] SEG_5 = 7'b0100100;
    localparam logic [0:6] SEG_6 = 7'b0100000;
    localparam logic [0:6] SEG_7 = 7'b0001111;
    localparam logic [0:6] SEG_8 = 7'b0000000;
    localparam logic [0:6] SEG_9 = 7'b0000100;
    localparam logic [0:6] SEG_A = 7'b0001000;
    localparam logic [0:6] SEG_B = 7'b1100000;
    localparam logic [0:6] SEG_C = 7'b0110001;
    localparam logic [0:6] SEG_D = 7'b1000010;
    localparam logic [0:6] SEG_E = 7'b0110000;
    localparam logic [0:6] SEG_F = 7'b0111000;

    localparam logic [3:0] MASK_ALL = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

endpackage

// File: rtl/seg7_inverse.sv
// Combinational inverse of the nibble-to-segment encoder: maps an active-low
// segment pattern back to its hex nibble and flags patterns outside the table.
module seg7_inverse
    import seg_scan_decoder_pkg::*;
(
    input  logic [0:6] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds a 16-bit word from a 4-digit multiplexed 7-segment scan bus and
// reports each frame as committed, discarded (bad sample) or timed out.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [0:6]  seg,
    input  logic [3:0]  digit_sel,
    input  logic        seg_strobe,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic        timeout,
    output logic        busy
);

    state_t        state, state_d;
    logic [3:0]    mask, mask_d;
    logic          bad, bad_d;
    logic [CW-1:0] timer, timer_d;
    logic [3:0]    nibbles   [4];
    logic [3:0]    nibbles_d [4];
    logic [15:0]   value_d;
    logic          valid_d, err_d, timeout_d;

    logic       dec_legal;
    logic [3:0] dec_nibble;
    logic       sample_ok;
    logic [3:0] sample_mask;
    logic       complete;

    seg7_inverse u_inverse (
        .seg    (seg),
        .legal  (dec_legal),
        .nibble (dec_nibble)
    );

    assign sample_ok   = seg_strobe && dec_legal && $onehot(digit_sel);
    assign sample_mask = sample_ok ? digit_sel : 4'b0000;
    // The completing digit is written this cycle, so test the post-update mask.
    assign complete    = sample_ok && ((mask | digit_sel) == MASK_ALL);
    assign busy        = (state == ST_COLLECT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state;
        mask_d    = mask;
        bad_d     = bad;
        timer_d   = timer;
        value_d   = value;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        nibbles_d = nibbles;

        for (int k = 0; k < 4; k++) begin
            if (sample_mask[k]) nibbles_d[k] = dec_nibble;
        end

        case (state)
            ST_IDLE: begin
                if (seg_strobe) begin
                    state_d = ST_COLLECT;
                    timer_d = '0;
                    mask_d  = sample_mask;
                    bad_d   = !sample_ok;
                end
            end
            ST_COLLECT: begin
                timer_d = timer + CW'(1);
                mask_d  = mask | sample_mask;
                bad_d   = bad || (seg_strobe && !sample_ok);
                // Completion takes priority over a coincident timeout.
                if (complete || timer == CW'(TIMEOUT - 1)) begin
                    if (!complete)  timeout_d = 1'b1;
                    else if (bad)   err_d     = 1'b1;
                    else begin
                        valid_d = 1'b1;
                        value_d = {nibbles_d[3], nibbles_d[2], nibbles_d[1], nibbles_d[0]};
                    end
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    bad_d   = 1'b0;
                    timer_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            mask        <= '0;
            bad         <= 1'b0;
            timer       <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
            // NOTE: the nibble bank is tiny and must read as zero after reset, so it is reset like any flop.
            nibbles     <= '{default: 4'h0};
        end else begin
            state       <= state_d;
            mask        <= mask_d;
            bad         <= bad_d;
            timer       <= timer_d;
            value       <= value_d;
            value_valid <= valid_d;
            frame_err   <= err_d;
            timeout     <= timeout_d;
            nibbles     <= nibbles_d;
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart to the counter/7-segment display path: reconstructs a 16-bit value from a time-multiplexed, 4-digit, active-low 7-segment scan bus.
- Samples one digit per strobe, inverse-decodes each segment pattern to a hex nibble, and assembles the 4 digits into a frame.
- Commits the frame as a validated word, or flags it as an error or timeout.
- Used to loop display outputs back into logic for self-check and to read peer-board displays.

Parameters:
- TIMEOUT, 1024, clock cycles allowed from the first accepted sample of a frame to frame completion. Minimum 4.
- CW, 11, width of the timeout counter. Must satisfy 2^CW > TIMEOUT.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- seg  input  [0:6]  segment pattern; seg[0]=a … seg[6]=g; active-low (0 = lit).
- digit_sel  input  4  one-hot digit select, active-high. Bit k is digit k, which carries value[4k+3:4k].
- seg_strobe  input  1  sample qualifier; seg and digit_sel are sampled only when this is 1.
- value  output  16  last committed word.
- value_valid  output  1  one-cycle pulse on commit.
- frame_err  output  1  one-cycle pulse when a frame is discarded for a bad sample.
- timeout  output  1  one-cycle pulse when a frame is aborted by timeout.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, resetn=0): value=0, value_valid=0, frame_err=0, timeout=0, busy=0, digit mask=0, bad flag=0, timer=0. The bank of four nibble registers is cleared. Reset mid-frame discards all partial state.
- Legal patterns, given as seg[0..6]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern is illegal.
- Accepted sample: seg_strobe=1. The sample is bad if digit_sel is not exactly one-hot or the pattern is illegal.
  - Good sample: nibble[k] is written with the decoded value and mask[k] is set.
  - Bad sample: the bad flag is set; no mask or nibble update.
  - A repeated digit within a frame overwrites its nibble (latest wins) and is not an error.
- State machine IDLE/COLLECT:
  - IDLE: busy=0. Any accepted sample moves to COLLECT and loads timer=0.
  - COLLECT: busy=1; timer increments every cycle.
- Commit check: evaluated in the same cycle a sample makes mask=1111.
  - Bad flag clear: next cycle value = {nibble3, nibble2, nibble1, nibble0} and value_valid=1.
  - Bad flag set: next cycle frame_err=1 and value is unchanged.
  - Either way, mask, bad flag and timer clear and the state returns to IDLE.
  - Latency: one cycle from the completing strobe edge to the pulse.
- Timeout: in COLLECT, when timer reaches TIMEOUT-1 without completion, the next cycle gives timeout=1. Mask and bad flag clear, the state goes to IDLE, and value is unchanged.
  - If completion and timeout coincide in the same cycle, completion wins and no timeout pulse is issued.
- A strobe arriving in the cycle the FSM returns to IDLE starts a new frame. Back-to-back frames lose no samples.
- Only one of value_valid, frame_err and timeout is ever high in a given cycle.

Decomposition:
- Shared package:
  - The 16-entry legal pattern table (constants SEG_0 … SEG_F).
  - The FSM state encoding (ST_IDLE, ST_COLLECT).
  - The all-digits mask constant 4'b1111.
- One sub-module, seg7_inverse: combinational, seg[0:6] → {legal, nibble[3:0]}. It is the exact inverse of the team's existing nibble→segment encoder. The bench drives it through that encoder for an exhaustive check.

Test Plan:
- Exhaustive decode: all 128 seg values through seg7_inverse → legal=1 for exactly the 16 table entries, with the matching nibble. Drive 0–F through the existing encoder and back → identity.
- Clean frame: strobe digit0=0100100(5), digit1=0000001(0), digit2=0001000(A), digit3=0000000(8) → value=16'h8A05 and value_valid one cycle after the 4th strobe; busy falls on the same edge.
- Overwrite: digit0=1, digit1=2, digit0=7, digit2=3, digit3=4 → value=16'h4327, single valid pulse.
- Bad sample: frame with digit_sel=4'b0110 on one strobe, or seg=1111111 → frame_err pulse on completion; value keeps its prior 16'h8A05; no valid pulse.
- Timeout (TIMEOUT=8): strobe digits 0 and 1 only → timeout pulse 8 cycles after the first strobe. The next full frame 1,2,3,4 → value=16'h4321.
- Reset mid-frame: three digits in, then resetn low for 1 cycle → value=0 and busy=0 immediately (async). The completing 4th strobe afterwards only starts a new frame; no valid pulse.
